// File: rtl/adder_slice_sequencer.sv
// Computes a WIDTH-bit A+B+cin by driving a shared external 2-bit ripple adder slice,
// two bits per cycle LSB-first, with the slice carry held in a flop between cycles.
module adder_slice_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       slice_a,
   output logic [1:0]       slice_b,
   output logic             slice_cin,
   input  logic [1:0]       slice_sum,
   input  logic             slice_cout,
   output logic             busy
);
   localparam int NSLICE = WIDTH / 2;
   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic [IW:0]      bit_base;

   assign bit_base = {idx_q, 1'b0};
   assign sum      = sum_q;
   assign cout     = cout_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      slice_a   = 2'b00;
      slice_b   = 2'b00;
      slice_cin = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Gated by rst_n so in_ready reads low for the whole reset window.
            in_ready = rst_n;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            busy      = 1'b1;
            slice_a   = a_q[bit_base +: 2];
            slice_b   = b_q[bit_base +: 2];
            slice_cin = carry_q;
            sum_d[bit_base +: 2] = slice_sum;
            carry_d   = slice_cout;
            idx_d     = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_cout;
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end
endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Directed bench for adder_slice_sequencer (WIDTH=8) with a behavioural 2-bit slice.
module tb_adder_slice_sequencer;
   typedef struct packed {
      logic [7:0] s;
      logic       c;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       cin = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] sum;
   logic       cout;
   logic [1:0] slice_a;
   logic [1:0] slice_b;
   logic       slice_cin;
   logic [1:0] slice_sum;
   logic       slice_cout;
   logic       busy;

   int   n_cmp = 0;
   int   n_fail = 0;
   res_t sb[$];

   adder_slice_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout),
      .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
      .slice_sum(slice_sum), .slice_cout(slice_cout),
      .busy(busy)
   );

   always #5 clk = ~clk;

   assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {2'b00, slice_cin};

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %b, expected %b", tag, got, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge right after the accept edge.
   task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                           input bit change_after);
      logic [8:0] t;
      a = ta; b = tb; cin = tcin; in_valid = 1'b1;
      chk1("in_ready_idle", in_ready, 1'b1);
      t = {1'b0, ta} + {1'b0, tb} + {8'h00, tcin};
      sb.push_back('{s: t[7:0], c: t[8]});
      @(negedge clk);
      in_valid = 1'b0;
      if (change_after) begin
         a = ~ta; b = ~tb; cin = ~tcin;
      end
   endtask

   // Walks the four RUN cycles checking the slice drive against a bench-side carry chain.
   task automatic track_run(input logic [7:0] ta, input logic [7:0] tb, input logic tcin);
      logic       c;
      logic [2:0] p;
      c = tcin;
      for (int k = 0; k < 4; k++) begin
         chk1("busy_run", busy, 1'b1);
         chk1("in_ready_run", in_ready, 1'b0);
         chk1("out_valid_run", out_valid, 1'b0);
         chk2("slice_a", slice_a, ta[2*k +: 2]);
         chk2("slice_b", slice_b, tb[2*k +: 2]);
         chk1("slice_cin", slice_cin, c);
         p = {1'b0, ta[2*k +: 2]} + {1'b0, tb[2*k +: 2]} + {2'b00, c};
         c = p[2];
         @(negedge clk);
      end
   endtask

   task automatic check_result(output res_t r);
      chk1("out_valid_done", out_valid, 1'b1);
      chk1("busy_done", busy, 1'b0);
      chk1("in_ready_done", in_ready, 1'b0);
      chk2("slice_a_done", slice_a, 2'b00);
      chk1("sb_nonempty", sb.size() != 0, 1'b1);
      r = '0;
      if (sb.size() != 0) begin
         r = sb.pop_front();
         chk8("sum", sum, r.s);
         chk1("cout", cout, r.c);
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk1("out_valid_after_hs", out_valid, 1'b0);
      chk1("in_ready_after_hs", in_ready, 1'b1);
   endtask

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                         input bit change_after);
      res_t r;
      start_op(ta, tb, tcin, change_after);
      track_run(ta, tb, tcin);
      check_result(r);
      consume();
   endtask

   initial begin
      res_t r;
      #2;
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk8("rst_sum", sum, 8'h00);
      chk1("rst_cout", cout, 1'b0);
      chk2("rst_slice_a", slice_a, 2'b00);
      chk1("rst_slice_cin", slice_cin, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk1("idle_in_ready", in_ready, 1'b1);
      @(negedge clk);

      run_op(8'h00, 8'h00, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0);
      run_op(8'hA5, 8'h5A, 1'b1, 1'b0);
      run_op(8'h03, 8'h01, 1'b1, 1'b0);

      // Backpressure: result must hold while new operands are waved at the input.
      start_op(8'h3C, 8'h4B, 1'b0, 1'b0);
      track_run(8'h3C, 8'h4B, 1'b0);
      check_result(r);
      for (int i = 0; i < 3; i++) begin
         in_valid = ~in_valid;
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         @(negedge clk);
         chk1("bp_out_valid", out_valid, 1'b1);
         chk1("bp_in_ready", in_ready, 1'b0);
         chk8("bp_sum", sum, r.s);
         chk1("bp_cout", cout, r.c);
      end
      in_valid = 1'b0;
      consume();
      run_op(8'h33, 8'h44, 1'b0, 1'b0);

      // Asynchronous reset during the k=2 RUN cycle aborts the operation.
      start_op(8'hC7, 8'h9E, 1'b1, 1'b0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      chk1("pre_abort_busy", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_out_valid", out_valid, 1'b0);
      chk1("abort_in_ready", in_ready, 1'b0);
      chk8("abort_sum", sum, 8'h00);
      chk1("abort_cout", cout, 1'b0);
      chk2("abort_slice_b", slice_b, 2'b00);
      chk1("abort_slice_cin", slice_cin, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk1("post_abort_no_out_valid", out_valid, 1'b0);
         @(negedge clk);
      end
      run_op(8'h10, 8'h20, 1'b0, 1'b0);

      // Operand changes after the accept edge must not leak into the result.
      run_op(8'h6D, 8'hB2, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
